// File: rtl/vending_machine_chg.sv
// Vending controller: takes 1/2/5 CNY coin pulses, vends at PRICE, returns change or a full refund.
// Optional inactivity timeout in COLLECT is built when VM_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module vending_machine_chg #(
  parameter int PRICE       = 6,
  parameter int SUM_W       = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_one_cny,
  input  logic             i_two_cny,
  input  logic             i_five_cny,
  input  logic             i_cancel,
  output logic             o_ready,
  output logic             o_done,
  output logic             o_change_vld,
  output logic             o_refund_vld,
  output logic [SUM_W-1:0] o_change
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    VEND    = 3'd2,
    CHANGE  = 3'd3,
    REFUND  = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [SUM_W-1:0] sum, sum_nx, coin_val;
  logic             coin, accept, timeout;

  // Priority one > two > five; lower-priority coins in the same cycle are dropped.
  always_comb begin
    coin_val = '0;
    if (i_one_cny)       coin_val = SUM_W'(1);
    else if (i_two_cny)  coin_val = SUM_W'(2);
    else if (i_five_cny) coin_val = SUM_W'(5);
  end

  assign coin   = i_one_cny | i_two_cny | i_five_cny;
  assign accept = coin && (state == IDLE || state == COLLECT);
  assign sum_nx = sum + coin_val;

`ifdef VM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cnt <= '0;
    else if (state != COLLECT || coin) cnt <= '0;
    else                             cnt <= cnt + CNT_W'(1);
  end

  assign timeout = (state == COLLECT) && !coin && !i_cancel &&
                   (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (coin) state_nx = (sum_nx >= SUM_W'(PRICE)) ? VEND : COLLECT;
      // Cancel (or timeout) beats reaching the price; a same-cycle coin still lands in sum.
      COLLECT: if (i_cancel || timeout) state_nx = REFUND;
               else if (coin)           state_nx = (sum_nx >= SUM_W'(PRICE)) ? VEND : COLLECT;
      VEND:    state_nx = CHANGE;
      CHANGE:  state_nx = IDLE;
      REFUND:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                             sum <= '0;
    else if (accept)                                      sum <= sum_nx;
    else if (!(state inside {IDLE, COLLECT, VEND}))       sum <= '0;
  end

  assign o_ready      = (state == IDLE) || (state == COLLECT);
  assign o_done       = (state == VEND);
  assign o_change_vld = (state == CHANGE);
  assign o_refund_vld = (state == REFUND);

  always_comb begin
    o_change = '0;
    if (state == CHANGE)      o_change = sum - SUM_W'(PRICE);
    else if (state == REFUND) o_change = sum;
  end

endmodule
